// File: rtl/store_merge_unit.sv
// Store path for a word-only data memory: sb/sh become read-modify-write,
// sw goes straight to memory, and misaligned or invalid sizes are rejected.
//
// state | meaning
// IDLE  | ready; accept and classify a store request
// RD    | read the containing word for a byte/half merge
// WR    | write the word buffer to memory
// DONE  | one-cycle commit pulse
// ERR   | one-cycle reject pulse, memory untouched
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_done,
    output logic              st_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic [1:0]        r_size;
    logic [31:0]       r_wbuf;
    logic              w_misalign;
    logic [31:0]       w_merged;

    always_comb begin
        w_misalign = 1'b0;
        case (st_size)
            SZ_HALF: w_misalign = st_addr[0];
            SZ_WORD: w_misalign = (st_addr[1:0] != 2'b00);
            SZ_BYTE: w_misalign = 1'b0;
            default: w_misalign = 1'b1;
        endcase
    end

    // Little-endian lane replacement; untouched lanes keep the memory contents.
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == SZ_HALF) begin
            if (r_addr[1]) w_merged[31:16] = r_data;
            else           w_merged[15:0]  = r_data;
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (st_valid) begin
                    if (w_misalign)           w_next = ERR;
                    else if (st_size == SZ_WORD) w_next = WR;
                    else                      w_next = RD;
                end
            end
            RD:      if (mem_ack) w_next = WR;
            WR:      if (mem_ack) w_next = DONE;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        st_ready    = (r_state == IDLE) & ~rst;
        st_done     = (r_state == DONE);
        st_misalign = (r_state == ERR);
        mem_req     = (r_state == RD) | (r_state == WR);
        mem_we      = (r_state == WR);
    end

    // Capture only in the accept cycle so the memory side stays stable while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_size <= '0;
            r_wbuf <= '0;
        end else begin
            if (r_state == IDLE && st_valid) begin
                r_addr <= st_addr;
                r_data <= st_data[15:0];
                r_size <= st_size;
                if (st_size == SZ_WORD) r_wbuf <= st_data;
            end else if (r_state == RD && mem_ack) begin
                r_wbuf <= w_merged;
            end
        end
    end

    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = r_wbuf;

endmodule
